// File: rtl/sdram_rw_sched.sv
// -----------------------------------------------------------------------------
// sdram_rw_sched
//
// Request scheduler placed in front of sdram_control. Level write/read burst
// requests from the port-side FIFO logic are arbitrated round-robin. Each grant
// produces a single-cycle Wr or Rd command pulse. Independent write and read
// address pointers auto-increment by one burst per completed transfer, with
// column -> row -> wrap rollover. A burst counts as complete when the
// controller's data-valid window has been seen and has closed again.
//
// Optional feature macro: SDRAM_SCHED_TIMEOUT_EN
//   defined   : a watchdog counts WAIT cycles. When it reaches TIMEOUT, the
//               FSM abandons the burst, sets sticky Timeout_err and leaves
//               the pointer alone so the same address is retried.
//   undefined : no watchdog, WAIT lasts until completion, Timeout_err = 0.
//
// Ports
//   Clk            system clock (single domain)
//   Rst_n          asynchronous active-low reset
//   Wr_req         write burst pending (level)
//   Rd_req         read burst pending (level)
//   Wr_bank        bank used for write bursts
//   Rd_bank        bank used for read bursts
//   Addr_clr       clear both pointers (honoured in IDLE only)
//   Wr_data_vaild  controller write data window
//   Rd_data_vaild  controller read data window
//   Wr / Rd        one-cycle command pulses
//   Caddr/Raddr/Baddr  column / row / bank of the burst being issued
//   Wr_done/Rd_done    one-cycle burst completion pulses
//   Busy           FSM not in IDLE
//   Timeout_err    sticky watchdog flag
// -----------------------------------------------------------------------------
module sdram_rw_sched #(
    parameter int ASIZE   = 12,
    parameter int BSIZE   = 2,
    parameter int BL      = 8,
    parameter int COL_MAX = 512,
    parameter int ROW_MAX = 4096,
    parameter int TIMEOUT = 255
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Wr_req,
    input  logic             Rd_req,
    input  logic [BSIZE-1:0] Wr_bank,
    input  logic [BSIZE-1:0] Rd_bank,
    input  logic             Addr_clr,
    input  logic             Wr_data_vaild,
    input  logic             Rd_data_vaild,
    output logic             Wr,
    output logic             Rd,
    output logic [ASIZE-1:0] Caddr,
    output logic [ASIZE-1:0] Raddr,
    output logic [BSIZE-1:0] Baddr,
    output logic             Wr_done,
    output logic             Rd_done,
    output logic             Busy,
    output logic             Timeout_err
);

    localparam logic [ASIZE-1:0] COL_STEP = ASIZE'(BL);
    localparam logic [ASIZE-1:0] COL_LAST = ASIZE'(COL_MAX - BL);
    localparam logic [ASIZE-1:0] ROW_LAST = ASIZE'(ROW_MAX - 1);
    localparam logic [ASIZE-1:0] ROW_ONE  = ASIZE'(1);

    // Pointer index 0 is the write pointer, index 1 the read pointer.
    localparam int PW = 0;
    localparam int PR = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ISSUE,
        S_WR_WAIT,
        S_RD_ISSUE,
        S_RD_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic               seen_q, seen_d;
    logic               last_wr_q, last_wr_d;   // 1: last served burst was a write
    logic               wr_q, wr_d;
    logic               rd_q, rd_d;
    logic               wr_done_q, wr_done_d;
    logic               rd_done_q, rd_done_d;
    logic [ASIZE-1:0]   caddr_q, caddr_d;
    logic [ASIZE-1:0]   raddr_q, raddr_d;
    logic [BSIZE-1:0]   baddr_q, baddr_d;

    logic [ASIZE-1:0]   col_q   [2];
    logic [ASIZE-1:0]   col_d   [2];
    logic [ASIZE-1:0]   row_q   [2];
    logic [ASIZE-1:0]   row_d   [2];
    logic [ASIZE-1:0]   col_adv [2];
    logic [ASIZE-1:0]   row_adv [2];

    logic               in_wait;
    logic               wait_valid;
    logic               complete;
    logic               expire;

    // -------------------------------------------------------------------------
    // Address pointers: advance value and storage for each direction
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
            logic col_wrap;

            assign col_wrap     = (col_q[gi] == COL_LAST);
            assign col_adv[gi]  = col_wrap ? '0 : col_q[gi] + COL_STEP;
            assign row_adv[gi]  = !col_wrap              ? row_q[gi] :
                                  (row_q[gi] == ROW_LAST) ? '0        :
                                                            row_q[gi] + ROW_ONE;

            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    col_q[gi] <= '0;
                    row_q[gi] <= '0;
                end else begin
                    col_q[gi] <= col_d[gi];
                    row_q[gi] <= row_d[gi];
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Completion detection. The valid window must have been seen in WAIT and
    // then be sampled low; a valid already high during ISSUE is ignored
    // because seen is only ever set from a WAIT state.
    // -------------------------------------------------------------------------
    assign in_wait    = (state_q == S_WR_WAIT) || (state_q == S_RD_WAIT);
    assign wait_valid = (state_q == S_WR_WAIT) ? Wr_data_vaild : Rd_data_vaild;
    assign complete   = in_wait && seen_q && !wait_valid;

    // -------------------------------------------------------------------------
    // Next-state / next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        seen_d    = seen_q;
        last_wr_d = last_wr_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        wr_done_d = 1'b0;
        rd_done_d = 1'b0;
        caddr_d   = caddr_q;
        raddr_d   = raddr_q;
        baddr_d   = baddr_q;
        col_d     = col_q;
        row_d     = row_q;

        case (state_q)
            S_IDLE: begin
                seen_d = 1'b0;
                if (Addr_clr) begin
                    // Clearing takes the whole cycle; the issued address
                    // registers keep showing the previous burst.
                    col_d[PW] = '0;
                    row_d[PW] = '0;
                    col_d[PR] = '0;
                    row_d[PR] = '0;
                end else if (Wr_req && (!Rd_req || !last_wr_q)) begin
                    state_d = S_WR_ISSUE;
                    wr_d    = 1'b1;
                    caddr_d = col_q[PW];
                    raddr_d = row_q[PW];
                    baddr_d = Wr_bank;
                end else if (Rd_req) begin
                    state_d = S_RD_ISSUE;
                    rd_d    = 1'b1;
                    caddr_d = col_q[PR];
                    raddr_d = row_q[PR];
                    baddr_d = Rd_bank;
                end
            end

            S_WR_ISSUE: state_d = S_WR_WAIT;
            S_RD_ISSUE: state_d = S_RD_WAIT;

            S_WR_WAIT, S_RD_WAIT: begin
                if (complete) begin
                    if (state_q == S_WR_WAIT) begin
                        col_d[PW] = col_adv[PW];
                        row_d[PW] = row_adv[PW];
                        wr_done_d = 1'b1;
                        last_wr_d = 1'b1;
                    end else begin
                        col_d[PR] = col_adv[PR];
                        row_d[PR] = row_adv[PR];
                        rd_done_d = 1'b1;
                        last_wr_d = 1'b0;
                    end
                    seen_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (expire) begin
                    // Abandon the burst without touching the pointer so the
                    // same address is retried on the next grant.
                    seen_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (wait_valid) begin
                    seen_d = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            seen_q    <= 1'b0;
            last_wr_q <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            caddr_q   <= '0;
            raddr_q   <= '0;
            baddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            seen_q    <= seen_d;
            last_wr_q <= last_wr_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            wr_done_q <= wr_done_d;
            rd_done_q <= rd_done_d;
            caddr_q   <= caddr_d;
            raddr_q   <= raddr_d;
            baddr_q   <= baddr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
`ifdef SDRAM_SCHED_TIMEOUT_EN
    localparam int               CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             err_q, err_d;

    // The counter holds the number of WAIT cycles already spent; the limit is
    // reached on the edge that would take it to TIMEOUT.
    assign expire = (wd_cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        err_d    = err_q;
        if ((state_q == S_WR_ISSUE) || (state_q == S_RD_ISSUE)) begin
            wd_cnt_d = '0;
        end else if (in_wait) begin
            wd_cnt_d = wd_cnt_q + CNT_ONE;
        end
        if (in_wait && !complete && expire) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

    assign Timeout_err = err_q;
`else
    // TIMEOUT only matters when the watchdog is built in.
    logic unused_timeout;
    assign unused_timeout = ^(32'(TIMEOUT));

    assign expire      = 1'b0;
    assign Timeout_err = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign Wr      = wr_q;
    assign Rd      = rd_q;
    assign Caddr   = caddr_q;
    assign Raddr   = raddr_q;
    assign Baddr   = baddr_q;
    assign Wr_done = wr_done_q;
    assign Rd_done = rd_done_q;
    assign Busy    = (state_q != S_IDLE);

endmodule
